// File: rtl/spi_tgt.sv
// spi_tgt: SPI mode-0 target that bridges an external initiator to a local memory port.
// Frame: R/W bit (1 = read), ADDR_W address bits, DATA_W data bits, all MSB first.
// Optional feature macro: SPI_TGT_BURST_EN keeps streaming words with an auto-incrementing
// address while CS stays low; without it each frame carries a single word.
module spi_tgt #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk_in,
  input  logic              cs_in,
  input  logic              mosi_in,
  output logic              miso_out,
  output logic              miso_oe_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_wdata_out,
  output logic              mem_we_out,
  output logic              mem_re_out,
  input  logic [DATA_W-1:0] mem_rdata_in,
  output logic              busy_out
);

  localparam int unsigned MaxW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned CntW = $clog2(MaxW + 1);

  typedef enum logic [1:0] {StIdle, StHdr, StData, StWaitCs} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_dly_q;
  logic                   sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall;

  state_e              state_q, state_d;
  logic [CntW-1:0]     bitcnt_q, bitcnt_d;
  logic [ADDR_W-1:0]   hdr_q, hdr_d;
  logic [ADDR_W:0]     hdr_full;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic                we_q, we_d, re_q, re_d, ld_q;
  logic                miso_q, miso_d, oe_q, oe_d, busy_q, busy_d;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;

  // Input synchronizers plus one extra SCLK flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_in};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
      sclk_dly_q  <= sclk_s;
    end
  end

  // Frame decoder: next state, shift registers and strobes.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    hdr_d    = hdr_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    tx_d     = tx_q;
    miso_d   = miso_q;
    we_d     = 1'b0;
    re_d     = 1'b0;
    hdr_full = {hdr_q, mosi_s};

    // Read data arrives one cycle after the read strobe.
    if (ld_q) tx_d = mem_rdata_in;
`ifdef SPI_TGT_BURST_EN
    // Advance only after the write strobe has gone out with the old address.
    if (we_q) addr_d = addr_q + ADDR_W'(1);
`endif

    unique case (state_q)
      StIdle: begin
        if (!cs_s) begin
          state_d  = StHdr;
          bitcnt_d = '0;
          hdr_d    = '0;
        end
      end
      StHdr: begin
        if (sclk_rise) begin
          hdr_d    = hdr_full[ADDR_W-1:0];
          bitcnt_d = bitcnt_q + CntW'(1);
          if (bitcnt_q == CntW'(ADDR_W)) begin
            rw_d     = hdr_full[ADDR_W];
            addr_d   = hdr_full[ADDR_W-1:0];
            re_d     = hdr_full[ADDR_W];
            bitcnt_d = '0;
            state_d  = StData;
          end
        end
      end
      StData: begin
        if (rw_q && sclk_fall) begin
          miso_d = tx_q[DATA_W-1];
          tx_d   = tx_q << 1;
        end
        if (sclk_rise) begin
          if (!rw_q) wdata_d = (wdata_q << 1) | DATA_W'(mosi_s);
          bitcnt_d = bitcnt_q + CntW'(1);
          if (bitcnt_q == CntW'(DATA_W - 1)) begin
            bitcnt_d = '0;
            we_d     = ~rw_q;
`ifdef SPI_TGT_BURST_EN
            if (rw_q) begin
              addr_d = addr_q + ADDR_W'(1);
              re_d   = 1'b1;
            end
`else
            state_d = StWaitCs;
`endif
          end
        end
      end
      StWaitCs: ;
      default: state_d = StIdle;
    endcase

    // CS release aborts any frame; a write not yet strobed is dropped.
    if (cs_s) begin
      state_d = StIdle;
      we_d    = 1'b0;
      re_d    = 1'b0;
    end

    oe_d   = (state_d == StData) && rw_d;
    busy_d = (state_d != StIdle);
    if (!oe_d) miso_d = 1'b0;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      bitcnt_q <= '0;
      hdr_q    <= '0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      tx_q     <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      ld_q     <= 1'b0;
      miso_q   <= 1'b0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      hdr_q    <= hdr_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      tx_q     <= tx_d;
      we_q     <= we_d;
      re_q     <= re_d;
      ld_q     <= re_q;
      miso_q   <= miso_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
    end
  end

  assign miso_out      = miso_q;
  assign miso_oe_out   = oe_q;
  assign mem_addr_out  = addr_q;
  assign mem_wdata_out = wdata_q;
  assign mem_we_out    = we_q;
  assign mem_re_out    = re_q;
  assign busy_out      = busy_q;

endmodule

// File: tb/tb_spi_tgt.sv
// tb_spi_tgt: directed SPI frames against spi_tgt with a transaction-level expectation model.
// Honours SPI_TGT_BURST_EN when the bench is built with it.
module tb_spi_tgt;

  localparam int HALF = 8;  // SCLK half period in clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk_in = 1'b0;
  logic       cs_in = 1'b1;
  logic       mosi_in = 1'b0;
  logic       miso_out, miso_oe_out, mem_we_out, mem_re_out, busy_out;
  logic [3:0] mem_addr_out;
  logic [7:0] mem_wdata_out;
  logic [7:0] mem_rdata;
  logic       mem_init = 1'b1;

  logic [7:0] dmem [16];     // memory attached to the DUT
  logic [7:0] ref_mem [16];  // model view of memory contents
  logic [3:0] exp_wa [$];
  logic [7:0] exp_wd [$];
  logic [3:0] exp_ra [$];
  int         wr_idx = 0;
  int         rd_idx = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] rx;

  always #5 clk = ~clk;

  spi_tgt #(
    .DATA_W     (8),
    .ADDR_W     (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sclk_in      (sclk_in),
    .cs_in        (cs_in),
    .mosi_in      (mosi_in),
    .miso_out     (miso_out),
    .miso_oe_out  (miso_oe_out),
    .mem_addr_out (mem_addr_out),
    .mem_wdata_out(mem_wdata_out),
    .mem_we_out   (mem_we_out),
    .mem_re_out   (mem_re_out),
    .mem_rdata_in (mem_rdata),
    .busy_out     (busy_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Local data memory: read data valid the cycle after mem_re_out.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) dmem[i] <= 8'h00;
      dmem[5]   <= 8'h3C;
      mem_rdata <= 8'h00;
    end else begin
      if (mem_we_out) dmem[mem_addr_out] <= mem_wdata_out;
      if (mem_re_out) mem_rdata <= dmem[mem_addr_out];
    end
  end

  // Compare every memory strobe against the expected transaction list.
  always @(negedge clk) begin
    if (!rst && !mem_init) begin
      check("we_re_exclusive", {31'd0, mem_we_out & mem_re_out}, 32'd0);
      if (mem_we_out) begin
        check("we_expected", {31'd0, wr_idx < exp_wa.size()}, 32'd1);
        if (wr_idx < exp_wa.size()) begin
          check("we_addr", {28'd0, mem_addr_out}, {28'd0, exp_wa[wr_idx]});
          check("we_data", {24'd0, mem_wdata_out}, {24'd0, exp_wd[wr_idx]});
        end
        wr_idx++;
      end
      if (mem_re_out) begin
        check("re_expected", {31'd0, rd_idx < exp_ra.size()}, 32'd1);
        if (rd_idx < exp_ra.size())
          check("re_addr", {28'd0, mem_addr_out}, {28'd0, exp_ra[rd_idx]});
        rd_idx++;
      end
    end
  end

  // One SPI frame of 'total' bits (header + data). ending: 0 = release CS, 1 = pulse rst.
  task automatic spi_frame(input bit rw, input logic [3:0] addr, input logic [15:0] data,
                           input int total, input int ending, input int gap,
                           output logic [7:0] word);
    int         dbits, words, nw;
    logic [7:0] rd_word;
    word    = 8'h00;
    rd_word = ref_mem[addr];
    // Expected strobes derived from the frame contents.
    if (total >= 5) begin
      dbits = total - 5;
      words = dbits / 8;
      if (rw) begin
        exp_ra.push_back(addr);
`ifdef SPI_TGT_BURST_EN
        for (int k = 1; k <= words; k++) exp_ra.push_back(4'(addr + k));
`endif
      end else begin
        nw = words;
`ifndef SPI_TGT_BURST_EN
        if (nw > 1) nw = 1;
`endif
        for (int k = 0; k < nw; k++) begin
          exp_wa.push_back(4'(addr + k));
          exp_wd.push_back(data[15 - 8 * k -: 8]);
          ref_mem[4'(addr + k)] = data[15 - 8 * k -: 8];
        end
      end
    end

    @(negedge clk);
    cs_in   = 1'b0;
    sclk_in = 1'b0;
    for (int i = 0; i < total; i++) begin
      logic b;
      int   j;
      j = i - 5;
      if (i == 0)     b = rw;
      else if (i < 5) b = addr[4 - i];
      else            b = rw ? 1'b0 : data[15 - j];
      mosi_in = b;
      repeat (HALF) @(negedge clk);
      // Initiator samples MISO just as SCLK rises.
      if (i < 5) check("oe_hdr", {31'd0, miso_oe_out}, 32'd0);
      if (rw && i >= 5 && j < 8) begin
        check("oe_data", {31'd0, miso_oe_out}, 32'd1);
        check("miso_bit", {31'd0, miso_out}, {31'd0, rd_word[7 - j]});
        word[7 - j] = miso_out;
      end
      sclk_in = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk_in = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    mosi_in = 1'b0;
    if (ending == 0) begin
      check("busy_in_frame", {31'd0, busy_out}, 32'd1);
      cs_in = 1'b1;
      repeat (gap - 1) @(negedge clk);
      check("busy_after_cs", {31'd0, busy_out}, 32'd0);
      check("oe_after_cs", {31'd0, miso_oe_out}, 32'd0);
    end else begin
      rst   = 1'b1;
      cs_in = 1'b1;
      @(negedge clk);
      check("rst_outputs", {12'd0, miso_out, miso_oe_out, mem_addr_out, mem_wdata_out,
                            mem_we_out, mem_re_out, busy_out}, 32'd0);
      rst = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    ref_mem[5] = 8'h3C;
    repeat (4) @(negedge clk);
    // Reset state.
    check("rst_miso", {31'd0, miso_out}, 32'd0);
    check("rst_oe", {31'd0, miso_oe_out}, 32'd0);
    check("rst_addr", {28'd0, mem_addr_out}, 32'd0);
    check("rst_wdata", {24'd0, mem_wdata_out}, 32'd0);
    check("rst_we", {31'd0, mem_we_out}, 32'd0);
    check("rst_re", {31'd0, mem_re_out}, 32'd0);
    check("rst_busy", {31'd0, busy_out}, 32'd0);
    rst      = 1'b0;
    mem_init = 1'b0;
    repeat (5) @(negedge clk);

    // Single write, then single read of preloaded data.
    spi_frame(1'b0, 4'h3, 16'hA500, 13, 0, 20, rx);
    check("dmem3", {24'd0, dmem[3]}, 32'h0000_00A5);
    spi_frame(1'b1, 4'h5, 16'h0000, 13, 0, 20, rx);
    check("rd5_word", {24'd0, rx}, 32'h0000_003C);

    // Write aborted after 6 data bits, then a good write.
    spi_frame(1'b0, 4'h6, 16'hFF00, 11, 0, 20, rx);
    check("abort_nowrite", {24'd0, dmem[6]}, 32'd0);
    spi_frame(1'b0, 4'h1, 16'h7700, 13, 0, 20, rx);
    check("dmem1", {24'd0, dmem[1]}, 32'h0000_0077);

    // Reset mid-header and mid-read-data, then a clean read.
    spi_frame(1'b1, 4'h9, 16'h0000, 3, 1, 20, rx);
    spi_frame(1'b1, 4'h5, 16'h0000, 8, 1, 20, rx);
    spi_frame(1'b1, 4'h3, 16'h0000, 13, 0, 20, rx);
    check("rd3_after_rst", {24'd0, rx}, 32'h0000_00A5);

    // Back-to-back frames with CS high for 4 clk.
    spi_frame(1'b0, 4'h2, 16'h1100, 13, 0, 4, rx);
    spi_frame(1'b1, 4'h2, 16'h0000, 13, 0, 20, rx);
    check("rd2_b2b", {24'd0, rx}, 32'h0000_0011);

    // Two words at 0xF: burst wraps to 0x0, single-word mode ignores the second.
    spi_frame(1'b0, 4'hF, 16'hDEAD, 21, 0, 20, rx);
    check("dmem15", {24'd0, dmem[15]}, 32'h0000_00DE);
`ifdef SPI_TGT_BURST_EN
    check("dmem0_burst", {24'd0, dmem[0]}, 32'h0000_00AD);
`else
    check("dmem0_single", {24'd0, dmem[0]}, 32'h0000_0000);
`endif

    repeat (10) @(negedge clk);
    check("we_total", wr_idx, exp_wa.size());
    check("re_total", rd_idx, exp_ra.size());
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
